exec_unit_mc: RTL

EXEC_UNIT_MC -- requirements
Module: exec_unit_mc

---
 rtl/exec_unit_mc.sv | 128 ++++++++++++
 1 files changed

// File: rtl/exec_unit_mc.sv
// Multi-cycle execution unit: single-cycle logic/shift/add ops plus iterative
// shift-add multiply and restoring divide, with a valid/ready handshake on both sides.
module exec_unit_mc #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] data_A,
  input  logic [XLEN-1:0] data_B,
  input  logic [3:0]      ALU_OP,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALU_OUT,
  output logic            zero,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              is_div;   // divide vs multiply
  logic              take_hi;  // mulhu / remu read the upper half
  logic [XLEN-1:0]   m_q;      // multiplicand or divisor
  logic [2*XLEN-1:0] p;        // {accumulator/remainder, multiplier/quotient}

  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   fast_res;
  logic              is_iter;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] p_next;
  logic [XLEN-1:0]   step_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign is_iter   = (ALU_OP >= 4'b1010) && (ALU_OP <= 4'b1101);
  assign shamt     = data_B[SHW-1:0];

  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    fast_res = '0;
    case (ALU_OP)
      4'b0000: fast_res = data_A & data_B;
      4'b0001: fast_res = data_A | data_B;
      4'b0010: fast_res = data_A ^ data_B;
      4'b0011: fast_res = data_A << shamt;
      4'b0100: fast_res = data_A >> shamt;
      4'b0101: fast_res = data_A + data_B;
      4'b0110: fast_res = data_A - data_B;
      4'b0111: fast_res = $signed(data_A) >>> shamt;
      4'b1000: fast_res = {{(XLEN-1){1'b0}}, $signed(data_A) < $signed(data_B)};
      4'b1001: fast_res = {{(XLEN-1){1'b0}}, data_A < data_B};
      default: fast_res = '0;
    endcase
  end

  // One iteration: multiply adds m_q when the multiplier LSB is set then shifts right;
  // divide shifts the next dividend bit into the remainder and subtracts if it fits.
  always_comb begin
    mul_sum   = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m_q} : '0);
    div_shift = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    div_diff  = div_shift - {1'b0, m_q};
    if (is_div)
      p_next = {(div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                p[XLEN-2:0], ~div_diff[XLEN]};
    else
      p_next = {mul_sum, p[XLEN-1:1]};
    step_res = take_hi ? p_next[2*XLEN-1:XLEN] : p_next[XLEN-1:0];
  end

  // NOTE: all sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      take_hi <= 1'b0;
      m_q     <= '0;
      p       <= '0;
      ALU_OUT <= '0;
      zero    <= 1'b1;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (is_iter) begin
            is_div  <= ALU_OP[2];
            take_hi <= ALU_OP[0];
            m_q     <= ALU_OP[2] ? data_B : data_A;
            p       <= {{XLEN{1'b0}}, (ALU_OP[2] ? data_A : data_B)};
            cnt     <= '0;
            state   <= BUSY;
          end else begin
            ALU_OUT <= fast_res;
            zero    <= (fast_res == '0);
            state   <= DONE;
          end
        end
        BUSY: begin
          p   <= p_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            ALU_OUT <= step_res;
            zero    <= (step_res == '0);
            state   <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
